// File: rtl/mem_access_unit.sv
// Memory-stage data-bus engine: launches one load/store per op on a split address/data
// handshake bus, aligns store lanes, extracts/extends load data and drains killed ops.
module mem_access_unit #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    input  logic                req_write,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    input  logic                flush,
    output logic                stall,
    output logic                resp_valid,
    output logic [XLEN-1:0]     resp_rdata,
    output logic                misalign,
    output logic                dreq_valid,
    output logic [ADDR_W-1:0]   dreq_addr,
    output logic [2:0]          dreq_size,
    output logic [XLEN/8-1:0]   dreq_strobe,
    output logic [XLEN-1:0]     dreq_data,
    input  logic                dresp_addr_ok,
    input  logic                dresp_data_ok,
    input  logic [XLEN-1:0]     dresp_data
);
    localparam int STRB_W = XLEN / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, DRAIN} state_t;

    function automatic logic [STRB_W-1:0] store_strobe(input logic [1:0] size,
                                                       input logic [OFF_W-1:0] off);
        logic [STRB_W-1:0] lanes;
        lanes = '0;
        for (int i = 0; i < STRB_W; i++) begin
            if (i < (1 << size)) lanes[i] = 1'b1;
        end
        return lanes << off;
    endfunction

    // Bits above the access width replicate its top bit unless zero-extension is requested.
    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] word,
                                                    input logic [OFF_W-1:0] off,
                                                    input logic [1:0] size,
                                                    input logic uns);
        logic [XLEN-1:0] shifted;
        logic [XLEN-1:0] result;
        logic            sign;
        shifted = word >> {off, 3'b000};
        result  = '0;
        sign    = 1'b0;
        for (int i = 0; i < XLEN; i++) begin
            if (i < (8 << size)) begin
                result[i] = shifted[i];
                sign      = shifted[i];
            end else begin
                result[i] = sign & ~uns;
            end
        end
        return result;
    endfunction

    state_t              state_q, state_d;
    logic                dreq_valid_q, dreq_valid_d;
    logic [ADDR_W-1:0]   dreq_addr_q, dreq_addr_d;
    logic [2:0]          dreq_size_q, dreq_size_d;
    logic [STRB_W-1:0]   dreq_strobe_q, dreq_strobe_d;
    logic [XLEN-1:0]     dreq_data_q, dreq_data_d;
    logic                op_write_q, op_write_d;
    logic                op_unsigned_q, op_unsigned_d;
    logic                resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]     resp_rdata_q, resp_rdata_d;
    logic                legal;
    logic                launch;
    logic [XLEN-1:0]     load_result;

    assign legal = ((1 << req_size) <= STRB_W) &&
                   ((req_addr[OFF_W-1:0] & OFF_W'((1 << req_size) - 1)) == '0);
    assign launch = req_valid && legal && !flush;
    assign load_result = op_write_q ? '0
                       : load_extend(dresp_data, dreq_addr_q[OFF_W-1:0], dreq_size_q[1:0],
                                     op_unsigned_q);

    always_comb begin
        state_d       = state_q;
        dreq_valid_d  = dreq_valid_q;
        dreq_addr_d   = dreq_addr_q;
        dreq_size_d   = dreq_size_q;
        dreq_strobe_d = dreq_strobe_q;
        dreq_data_d   = dreq_data_q;
        op_write_d    = op_write_q;
        op_unsigned_d = op_unsigned_q;
        resp_valid_d  = 1'b0;
        resp_rdata_d  = resp_rdata_q;
        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d       = ADDR;
                    dreq_valid_d  = 1'b1;
                    dreq_addr_d   = req_addr;
                    dreq_size_d   = {1'b0, req_size};
                    dreq_strobe_d = req_write ? store_strobe(req_size, req_addr[OFF_W-1:0]) : '0;
                    dreq_data_d   = req_write ? (req_wdata << {req_addr[OFF_W-1:0], 3'b000}) : '0;
                    op_write_d    = req_write;
                    op_unsigned_d = req_unsigned;
                end
            end
            ADDR: begin
                if (flush) begin
                    dreq_valid_d = 1'b0;
                    state_d      = (dresp_addr_ok && !dresp_data_ok) ? DRAIN : IDLE;
                end else if (dresp_addr_ok) begin
                    dreq_valid_d = 1'b0;
                    if (dresp_data_ok) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = load_result;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (dresp_data_ok) begin
                    if (flush) begin
                        state_d = IDLE;
                    end else begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = load_result;
                    end
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            RESP:    state_d = IDLE;
            DRAIN:   if (dresp_data_ok) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            dreq_valid_q  <= 1'b0;
            dreq_addr_q   <= '0;
            dreq_size_q   <= '0;
            dreq_strobe_q <= '0;
            dreq_data_q   <= '0;
            op_write_q    <= 1'b0;
            op_unsigned_q <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            dreq_valid_q  <= dreq_valid_d;
            dreq_addr_q   <= dreq_addr_d;
            dreq_size_q   <= dreq_size_d;
            dreq_strobe_q <= dreq_strobe_d;
            dreq_data_q   <= dreq_data_d;
            op_write_q    <= op_write_d;
            op_unsigned_q <= op_unsigned_d;
            resp_valid_q  <= resp_valid_d;
            resp_rdata_q  <= resp_rdata_d;
        end
    end

    // A flush arriving in RESP kills the response already sitting in the register.
    assign resp_valid  = resp_valid_q && !flush;
    assign resp_rdata  = resp_rdata_q;
    assign misalign    = req_valid && !legal && (state_q == IDLE);
    assign stall       = (state_q == IDLE && launch) || (state_q == ADDR) || (state_q == DATA) ||
                         (state_q == DRAIN && req_valid);
    assign dreq_valid  = dreq_valid_q;
    assign dreq_addr   = dreq_addr_q;
    assign dreq_size   = dreq_size_q;
    assign dreq_strobe = dreq_strobe_q;
    assign dreq_data   = dreq_data_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: vector table, hand-written flush/reset sequences and
// randomized ops against a byte-level reference model.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write, req_unsigned, flush;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata, dresp_data;
    logic        dresp_addr_ok, dresp_data_ok;
    logic        stall, resp_valid, misalign, dreq_valid;
    logic [63:0] resp_rdata, dreq_addr, dreq_data;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic        s32_stall, s32_resp_valid, s32_misalign, s32_dreq_valid;
    logic [31:0] s32_resp_rdata, s32_dreq_data;
    logic [63:0] s32_dreq_addr;
    logic [2:0]  s32_dreq_size;
    logic [3:0]  s32_dreq_strobe;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.XLEN(64), .ADDR_W(64)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .flush(flush), .stall(stall), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .misalign(misalign), .dreq_valid(dreq_valid),
        .dreq_addr(dreq_addr), .dreq_size(dreq_size), .dreq_strobe(dreq_strobe),
        .dreq_data(dreq_data), .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
        .dresp_data(dresp_data));

    mem_access_unit #(.XLEN(32), .ADDR_W(64)) dut32 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata[31:0]), .flush(flush), .stall(s32_stall),
        .resp_valid(s32_resp_valid), .resp_rdata(s32_resp_rdata), .misalign(s32_misalign),
        .dreq_valid(s32_dreq_valid), .dreq_addr(s32_dreq_addr), .dreq_size(s32_dreq_size),
        .dreq_strobe(s32_dreq_strobe), .dreq_data(s32_dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
        .dresp_data(dresp_data[31:0]));

    typedef struct {
        bit          w;
        logic [1:0]  sz;
        bit          u;
        logic [63:0] a, wd, bus;
        int          aw, dw;
        bit          mis;
        logic [63:0] rd;
        logic [7:0]  stb;
        logic [63:0] dat;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit m_legal(input logic [1:0] sz, input logic [63:0] a);
        int n = 1 << sz;
        return (n <= 8) && ((a % n) == 0);
    endfunction

    function automatic logic [63:0] m_load(input logic [63:0] bus, input logic [63:0] a,
                                           input logic [1:0] sz, input bit u);
        int n = 1 << sz;
        int off = int'(a % 8);
        logic [63:0] v = 0;
        for (int i = 0; i < n; i++) v = v | (((bus >> (8 * (off + i))) & 64'hFF) << (8 * i));
        if (!u && n < 8 && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
        return v;
    endfunction

    function automatic logic [7:0] m_strobe(input logic [63:0] a, input logic [1:0] sz);
        logic [7:0] s = 0;
        for (int i = 0; i < (1 << sz); i++) s[int'(a % 8) + i] = 1'b1;
        return s;
    endfunction

    task automatic do_op(input string nm, input bit w, input logic [1:0] sz, input bit u,
                         input logic [63:0] a, input logic [63:0] wd, input logic [63:0] bus,
                         input int aw, input int dw, input bit emis, input logic [63:0] erd,
                         input logic [7:0] estb, input logic [63:0] edat);
        req_valid = 1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = wd; flush = 0;
        dresp_addr_ok = 0; dresp_data_ok = 0;
        #1;
        chk({nm, ":misalign"}, misalign, emis);
        chk({nm, ":stall_idle"}, stall, !emis);
        if (emis) begin
            tick();
            chk({nm, ":no_dreq"}, dreq_valid, 0);
            req_valid = 0;
            return;
        end
        tick();
        for (int c = 0; c <= aw + dw; c++) begin
            dresp_addr_ok = (c == aw);
            dresp_data_ok = (c == aw + dw);
            dresp_data = dresp_data_ok ? bus : {$urandom, $urandom};
            #1;
            chk({nm, ":dreq_valid"}, dreq_valid, c <= aw);
            chk({nm, ":stall_busy"}, stall, 1);
            chk({nm, ":resp_early"}, resp_valid, 0);
            if (c == 0) begin
                chk({nm, ":dreq_addr"}, dreq_addr, a);
                chk({nm, ":dreq_size"}, dreq_size, {1'b0, sz});
                chk({nm, ":dreq_strobe"}, dreq_strobe, w ? estb : 8'h00);
                if (w) chk({nm, ":dreq_data"}, dreq_data, edat);
            end
            tick();
        end
        dresp_addr_ok = 0; dresp_data_ok = 0; req_valid = 0;
        #1;
        chk({nm, ":resp_valid"}, resp_valid, 1);
        chk({nm, ":stall_resp"}, stall, 0);
        chk({nm, ":dreq_idle"}, dreq_valid, 0);
        chk({nm, ":rdata"}, resp_rdata, w ? 64'h0 : erd);
        tick();
        chk({nm, ":resp_pulse"}, resp_valid, 0);
    endtask

    initial begin
        vec_t tv[16];
        tv[0]  = '{0, 0, 0, 64'h1003, 0, 64'h0000_0000_8000_0000, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FF80, 0, 0};
        tv[1]  = '{0, 0, 1, 64'h1003, 0, 64'h0000_0000_8000_0000, 0, 0, 0, 64'h80, 0, 0};
        tv[2]  = '{1, 1, 0, 64'h2006, 64'h1234, 0, 1, 2, 0, 0, 8'hC0, 64'h1234_0000_0000_0000};
        tv[3]  = '{0, 2, 0, 64'h1002, 0, 0, 0, 0, 1, 0, 0, 0};
        tv[4]  = '{0, 1, 0, 64'h1006, 0, 64'h8001_0000_0000_0000, 0, 3, 0, 64'hFFFF_FFFF_FFFF_8001, 0, 0};
        tv[5]  = '{0, 2, 1, 64'h1004, 0, 64'hDEAD_BEEF_0123_4567, 2, 0, 0, 64'hDEAD_BEEF, 0, 0};
        tv[6]  = '{0, 2, 0, 64'h1004, 0, 64'hDEAD_BEEF_0123_4567, 0, 1, 0, 64'hFFFF_FFFF_DEAD_BEEF, 0, 0};
        tv[7]  = '{0, 3, 0, 64'h1008, 0, 64'h0123_4567_89AB_CDEF, 1, 1, 0, 64'h0123_4567_89AB_CDEF, 0, 0};
        tv[8]  = '{1, 3, 0, 64'h3000, 64'hCAFE_F00D_1234_5678, 0, 0, 0, 0, 0, 8'hFF, 64'hCAFE_F00D_1234_5678};
        tv[9]  = '{1, 0, 0, 64'h3007, 64'hAB, 0, 0, 0, 0, 0, 8'h80, 64'hAB00_0000_0000_0000};
        tv[10] = '{0, 1, 0, 64'h1001, 0, 0, 0, 0, 1, 0, 0, 0};
        tv[11] = '{0, 3, 0, 64'h1004, 0, 0, 0, 0, 1, 0, 0, 0};
        tv[12] = '{0, 1, 1, 64'h1002, 0, 64'h0000_0000_F00D_0000, 0, 2, 0, 64'hF00D, 0, 0};
        tv[13] = '{1, 2, 0, 64'h3004, 64'h1122_3344, 0, 3, 0, 0, 0, 8'hF0, 64'h1122_3344_0000_0000};
        tv[14] = '{0, 0, 0, 64'h1005, 0, 64'h0000_7F00_0000_0000, 0, 0, 0, 64'h7F, 0, 0};
        tv[15] = '{1, 3, 0, 64'h3002, 64'h55, 0, 0, 0, 1, 0, 0, 0};

        reset = 1; req_valid = 0; req_write = 0; req_size = 0; req_unsigned = 0;
        req_addr = 0; req_wdata = 0; flush = 0;
        dresp_addr_ok = 0; dresp_data_ok = 0; dresp_data = 0;
        repeat (3) tick();
        reset = 0;
        #1;
        chk("rst:dreq_valid", dreq_valid, 0);
        chk("rst:dreq_addr", dreq_addr, 0);
        chk("rst:dreq_size", dreq_size, 0);
        chk("rst:dreq_strobe", dreq_strobe, 0);
        chk("rst:dreq_data", dreq_data, 0);
        chk("rst:resp_valid", resp_valid, 0);
        chk("rst:resp_rdata", resp_rdata, 0);
        chk("rst:stall", stall, 0);
        chk("rst:misalign", misalign, 0);

        // Narrow instance: doubleword accesses cannot exist on a 32-bit bus.
        req_valid = 1; req_size = 3; req_addr = 64'h1000;
        #1;
        chk("x32:ld_misalign", s32_misalign, 1);
        chk("x32:ld_stall", s32_stall, 0);
        chk("x64:ld_legal", misalign, 0);
        req_write = 1; req_size = 2;
        #1;
        chk("x32:sw_misalign", s32_misalign, 0);
        chk("x32:sw_stall", s32_stall, 1);
        req_valid = 0; req_write = 0;
        #1;

        for (int i = 0; i < 16; i++)
            do_op($sformatf("vec%0d", i), tv[i].w, tv[i].sz, tv[i].u, tv[i].a, tv[i].wd,
                  tv[i].bus, tv[i].aw, tv[i].dw, tv[i].mis, tv[i].rd, tv[i].stb, tv[i].dat);

        // Flush in DATA, drained response discarded, queued op launches afterwards.
        req_valid = 1; req_write = 0; req_size = 2; req_unsigned = 0; req_addr = 64'h1000;
        #1; tick();
        dresp_addr_ok = 1; #1; tick();
        dresp_addr_ok = 0; flush = 1; req_valid = 0; #1;
        chk("fdata:stall_data", stall, 1);
        tick();
        flush = 0; req_valid = 1; req_size = 3; req_addr = 64'h1008; #1;
        chk("fdata:drain_stall", stall, 1);
        chk("fdata:drain_resp", resp_valid, 0);
        chk("fdata:drain_dreq", dreq_valid, 0);
        tick();
        dresp_data_ok = 1; dresp_data = 64'h1111_2222_3333_4444; #1;
        chk("fdata:drain_ok_resp", resp_valid, 0);
        tick();
        dresp_data_ok = 0; #1;
        chk("fdata:idle_resp", resp_valid, 0);
        chk("fdata:idle_stall", stall, 1);
        chk("fdata:idle_dreq", dreq_valid, 0);
        tick();
        chk("fdata:relaunch", dreq_valid, 1);
        chk("fdata:relaunch_addr", dreq_addr, 64'h1008);
        dresp_addr_ok = 1; dresp_data_ok = 1; dresp_data = 64'h0F0E_0D0C_0B0A_0908; #1; tick();
        dresp_addr_ok = 0; dresp_data_ok = 0; req_valid = 0; #1;
        chk("fdata:relaunch_resp", resp_valid, 1);
        chk("fdata:relaunch_rdata", resp_rdata, 64'h0F0E_0D0C_0B0A_0908);
        tick();

        // Reset while the address phase is pending, then a stray bus response in IDLE.
        req_valid = 1; req_size = 2; req_addr = 64'h1000; #1; tick();
        chk("rstop:dreq_valid", dreq_valid, 1);
        reset = 1; req_valid = 0; tick();
        chk("rstop:dreq_cleared", dreq_valid, 0);
        chk("rstop:stall", stall, 0);
        chk("rstop:resp", resp_valid, 0);
        reset = 0; dresp_addr_ok = 1; dresp_data_ok = 1; #1; tick();
        dresp_addr_ok = 0; dresp_data_ok = 0; #1;
        chk("rstop:stray_resp", resp_valid, 0);
        chk("rstop:stray_dreq", dreq_valid, 0);

        // Flush in ADDR before the address is accepted.
        req_valid = 1; req_write = 1; req_size = 2; req_addr = 64'h3000; #1; tick();
        flush = 1; req_valid = 0; #1;
        chk("faddr:stall", stall, 1);
        tick();
        flush = 0; #1;
        chk("faddr:dreq_dropped", dreq_valid, 0);
        chk("faddr:stall_idle", stall, 0);
        tick();
        chk("faddr:no_resp", resp_valid, 0);

        // Flush coinciding with data_ok in DATA.
        req_valid = 1; req_write = 0; req_size = 2; req_addr = 64'h1000; #1; tick();
        dresp_addr_ok = 1; #1; tick();
        dresp_addr_ok = 0; dresp_data_ok = 1; flush = 1; req_valid = 0; #1; tick();
        dresp_data_ok = 0; flush = 0; #1;
        chk("fdok:no_resp", resp_valid, 0);
        chk("fdok:stall", stall, 0);
        tick();
        chk("fdok:no_resp_late", resp_valid, 0);

        // Flush during RESP suppresses the pulse.
        req_valid = 1; req_size = 0; req_addr = 64'h1000; #1; tick();
        dresp_addr_ok = 1; dresp_data_ok = 1; dresp_data = 64'hFF; #1; tick();
        dresp_addr_ok = 0; dresp_data_ok = 0; flush = 1; req_valid = 0; #1;
        chk("fresp:resp_killed", resp_valid, 0);
        tick();
        flush = 0; #1;
        chk("fresp:idle_resp", resp_valid, 0);
        chk("fresp:idle_stall", stall, 0);

        for (int i = 0; i < 150; i++) begin
            bit w = 1'($urandom_range(0, 1));
            bit u = 1'($urandom_range(0, 1));
            logic [1:0] sz = 2'($urandom_range(0, 3));
            logic [63:0] a = {$urandom, $urandom};
            logic [63:0] wd = {$urandom, $urandom};
            logic [63:0] bus = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 1);
            do_op($sformatf("rnd%0d", i), w, sz, u, a, wd, bus, $urandom_range(0, 3),
                  $urandom_range(0, 3), !m_legal(sz, a), m_load(bus, a, sz, u),
                  m_strobe(a, sz), wd << (8 * (a % 8)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
